ray_hit_accumulator: RTL and testbench

//  Sequential stage downstream of the per-batch closest-hit combiner. A ray's leaf primitives arrive
//  as batches of AABB_TEST_UNIT_SIZE; each batch yields one HitData. This block keeps the running

---
 rtl/ray_hit_accumulator_pkg.sv | 47 ++++
 rtl/ray_hit_accumulator_hit_select_min.sv | 16 +
 rtl/ray_hit_accumulator.sv | 144 ++++++++++++++
 tb/tb_ray_hit_accumulator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_hit_accumulator_pkg.sv
// Shared types for the ray hit accumulator: fixed-point distance, hit record, FSM states.
package ray_hit_accumulator_pkg;

  localparam int FIXED_W    = 32;
  localparam int FIXED_FRAC = 16;
  localparam int PI_W       = 16;
  localparam int COLOR_W    = 24;

  // Signed Q16.16 distance along the ray
  typedef logic signed [FIXED_W-1:0] Fixed;

  localparam Fixed FIXED_INF = {1'b0, {(FIXED_W-1){1'b1}}};

  typedef enum logic [1:0] {
    SURF_DIFFUSE  = 2'd0,
    SURF_SPECULAR = 2'd1,
    SURF_EMISSIVE = 2'd2,
    SURF_GLASS    = 2'd3
  } SurfaceType_t;

  typedef struct packed {
    logic               bHit;
    Fixed               T;
    logic [PI_W-1:0]    PI;
    SurfaceType_t       SurfaceType;
    logic [COLOR_W-1:0] Color;
  } HitData;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } AccState_t;

  localparam HitData HIT_NONE = '{
    bHit:        1'b0,
    T:           FIXED_INF,
    PI:          '0,
    SurfaceType: SURF_DIFFUSE,
    Color:       '0
  };

  function automatic Fixed FixedInf();
    return FIXED_INF;
  endfunction

endpackage

// File: rtl/ray_hit_accumulator_hit_select_min.sv
// Combinational closest-hit selector: the incoming hit wins only if it is a real hit and strictly nearer.
module hit_select_min
  import ray_hit_accumulator_pkg::*;
(
  input  HitData i_held,
  input  HitData i_incoming,
  output HitData o_winner
);

  logic w_takeIncoming;

  // Ties keep the held hit so the earliest batch wins
  assign w_takeIncoming = i_incoming.bHit && ($signed(i_held.T) > $signed(i_incoming.T));
  assign o_winner       = w_takeIncoming ? i_incoming : i_held;

endmodule

// File: rtl/ray_hit_accumulator.sv
// Running closest-hit accumulator across batches of one ray, with valid/ready result output.
// Optional saturating statistics counters enabled by defining RAY_HIT_ACC_STATS_EN.
module ray_hit_accumulator
  import ray_hit_accumulator_pkg::*;
#(
  parameter int RAY_ID_W = 6,
  parameter int STAT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  HitData              in_hit,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [RAY_ID_W-1:0] in_ray_id,
  output Fixed                cur_max_t,
  output logic                out_valid,
  input  logic                out_ready,
  output HitData              out_hit,
  output logic [RAY_ID_W-1:0] out_ray_id,
  output logic [STAT_W-1:0]   stat_batches,
  output logic [STAT_W-1:0]   stat_rays,
  output logic [STAT_W-1:0]   stat_proto_err
);

  AccState_t           r_state;
  AccState_t           w_nextState;
  HitData              r_best;
  HitData              w_winner;
  logic [RAY_ID_W-1:0] r_rayId;
  logic                w_accept;
  logic                w_loadFirst;
  logic                w_merge;
  logic                w_clear;

  assign in_ready   = (r_state != DONE);
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = (r_state == DONE);
  assign out_hit    = r_best;
  assign out_ray_id = r_rayId;
  assign cur_max_t  = r_best.T;

  hit_select_min u_hitSelectMin (
    .i_held     (r_best),
    .i_incoming (in_hit),
    .o_winner   (w_winner)
  );

  always_comb begin
    w_nextState = r_state;
    w_loadFirst = 1'b0;
    w_merge     = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && in_first) begin
          w_loadFirst = 1'b1;
          w_nextState = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        // A first beat here abandons the previous ray and restarts accumulation
        if (w_accept) begin
          if (in_first) begin
            w_loadFirst = 1'b1;
          end else begin
            w_merge = 1'b1;
          end
          if (in_last) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          w_clear     = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_best  <= HIT_NONE;
      r_rayId <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_loadFirst) begin
        r_best  <= in_hit.bHit ? in_hit : HIT_NONE;
        r_rayId <= in_ray_id;
      end else if (w_merge) begin
        r_best <= w_winner;
      end else if (w_clear) begin
        r_best <= HIT_NONE;
      end
    end
  end

`ifdef RAY_HIT_ACC_STATS_EN
  logic              w_protoErr;
  logic              w_rayDone;
  logic [STAT_W-1:0] r_statBatches;
  logic [STAT_W-1:0] r_statRays;
  logic [STAT_W-1:0] r_statProtoErr;

  assign w_protoErr = w_accept && (((r_state == IDLE) && !in_first) ||
                                   ((r_state == ACCUM) && in_first));
  assign w_rayDone  = (r_state == DONE) && out_ready;

  // Counters hold at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_statBatches  <= '0;
      r_statRays     <= '0;
      r_statProtoErr <= '0;
    end else begin
      if (w_accept && (r_statBatches != '1)) begin
        r_statBatches <= r_statBatches + 1'b1;
      end
      if (w_rayDone && (r_statRays != '1)) begin
        r_statRays <= r_statRays + 1'b1;
      end
      if (w_protoErr && (r_statProtoErr != '1)) begin
        r_statProtoErr <= r_statProtoErr + 1'b1;
      end
    end
  end

  assign stat_batches   = r_statBatches;
  assign stat_rays      = r_statRays;
  assign stat_proto_err = r_statProtoErr;
`else
  assign stat_batches   = '0;
  assign stat_rays      = '0;
  assign stat_proto_err = '0;
`endif

endmodule

// File: tb/tb_ray_hit_accumulator.sv
// Self-checking bench for ray_hit_accumulator: table-driven ray sequences plus hand-written
// back-pressure, asynchronous reset and protocol-error/statistics sequences.
module tb_ray_hit_accumulator;
  import ray_hit_accumulator_pkg::*;

  localparam int RAY_ID_W = 6;
  localparam int STAT_W   = 4;
  localparam int INF      = 9999;
  localparam int NV       = 16;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  HitData              in_hit;
  logic                in_first;
  logic                in_last;
  logic [RAY_ID_W-1:0] in_ray_id;
  Fixed                cur_max_t;
  logic                out_valid;
  logic                out_ready;
  HitData              out_hit;
  logic [RAY_ID_W-1:0] out_ray_id;
  logic [STAT_W-1:0]   stat_batches;
  logic [STAT_W-1:0]   stat_rays;
  logic [STAT_W-1:0]   stat_proto_err;

  int nChecks;
  int nFails;

  ray_hit_accumulator #(
    .RAY_ID_W (RAY_ID_W),
    .STAT_W   (STAT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_hit         (in_hit),
    .in_first       (in_first),
    .in_last        (in_last),
    .in_ray_id      (in_ray_id),
    .cur_max_t      (cur_max_t),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_hit        (out_hit),
    .out_ray_id     (out_ray_id),
    .stat_batches   (stat_batches),
    .stat_rays      (stat_rays),
    .stat_proto_err (stat_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    bit first;
    bit last;
    bit bHit;
    int t;
    int pi;
    int id;
    bit outReady;
    bit expValid;
    int expCur;
    bit expBHit;
    int expT;
    int expPi;
    int expId;
  } Vec_t;

  Vec_t vecs[NV];

  function automatic Fixed fx(input int t);
    if (t == INF) return FixedInf();
    return Fixed'(t * 65536);
  endfunction

  function automatic HitData makeHit(input bit bHit, input int t, input int pi);
    HitData h;
    h             = HIT_NONE;
    h.bHit        = bHit;
    h.T           = fx(t);
    h.PI          = PI_W'(pi);
    h.SurfaceType = SURF_SPECULAR;
    h.Color       = COLOR_W'(pi * 3 + 1);
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input bit first, input bit last, input bit bHit,
                               input int t, input int pi, input int id, input bit outReady);
    in_valid  = valid;
    in_first  = first;
    in_last   = last;
    in_hit    = makeHit(bHit, t, pi);
    in_ray_id = RAY_ID_W'(id);
    out_ready = outReady;
  endtask

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkResult(input string name, input bit bHit, input int t, input int pi,
                             input int id);
    checkOutput({name, " out_valid"}, longint'(out_valid), 1);
    checkOutput({name, " bHit"}, longint'(out_hit.bHit), longint'(bHit));
    checkOutput({name, " T"}, longint'($signed(out_hit.T)), longint'(fx(t)));
    if (bHit) checkOutput({name, " PI"}, longint'(out_hit.PI), longint'(pi));
    checkOutput({name, " ray_id"}, longint'(out_ray_id), longint'(id));
  endtask

  task automatic checkStats(input string name, input int batches, input int rays, input int proto);
`ifdef RAY_HIT_ACC_STATS_EN
    checkOutput({name, " stat_batches"}, longint'(stat_batches), longint'(batches));
    checkOutput({name, " stat_rays"}, longint'(stat_rays), longint'(rays));
    checkOutput({name, " stat_proto_err"}, longint'(stat_proto_err), longint'(proto));
`else
    checkOutput({name, " stat_batches"}, longint'(stat_batches), 0);
    checkOutput({name, " stat_rays"}, longint'(stat_rays), 0);
    checkOutput({name, " stat_proto_err"}, longint'(stat_proto_err), 0);
`endif
  endtask

  initial begin
    Vec_t v;
    nChecks = 0;
    nFails  = 0;
    reset   = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    //            vld fst lst hit  t    pi  id  ordy  eV  eCur eHit eT   ePi eId
    vecs[0]  = '{1, 1, 1, 1,  5,   1,  3,  1,   1,  5,   1,  5,   1,  3};
    vecs[1]  = '{0, 0, 0, 0,  0,   0,  0,  1,   0,  INF, 0,  0,   0,  0};
    vecs[2]  = '{1, 1, 0, 1,  8,   2,  5,  0,   0,  8,   0,  0,   0,  0};
    vecs[3]  = '{1, 0, 0, 1,  2,   3,  0,  0,   0,  2,   0,  0,   0,  0};
    vecs[4]  = '{1, 0, 1, 1,  4,   4,  0,  0,   1,  2,   1,  2,   3,  5};
    vecs[5]  = '{0, 0, 0, 0,  0,   0,  0,  1,   0,  INF, 0,  0,   0,  0};
    vecs[6]  = '{1, 1, 0, 1,  3,  10,  7,  0,   0,  3,   0,  0,   0,  0};
    vecs[7]  = '{1, 0, 0, 1,  3,  11,  0,  0,   0,  3,   0,  0,   0,  0};
    vecs[8]  = '{1, 0, 1, 0,  1,  12,  0,  0,   1,  3,   1,  3,  10,  7};
    vecs[9]  = '{0, 0, 0, 0,  0,   0,  0,  1,   0,  INF, 0,  0,   0,  0};
    vecs[10] = '{1, 1, 0, 0,  1,  20, 11,  0,   0,  INF, 0,  0,   0,  0};
    vecs[11] = '{1, 0, 1, 1,  6,  21,  0,  0,   1,  6,   1,  6,  21, 11};
    vecs[12] = '{0, 0, 0, 0,  0,   0,  0,  1,   0,  INF, 0,  0,   0,  0};
    vecs[13] = '{1, 1, 0, 1,  6,  30, 13,  0,   0,  6,   0,  0,   0,  0};
    vecs[14] = '{1, 0, 1, 1, -2,  31,  0,  0,   1, -2,   1, -2,  31, 13};
    vecs[15] = '{0, 0, 0, 0,  0,   0,  0,  1,   0,  INF, 0,  0,   0,  0};

    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    checkOutput("reset out_valid", longint'(out_valid), 0);
    checkOutput("reset in_ready", longint'(in_ready), 1);
    checkOutput("reset cur_max_t", longint'($signed(cur_max_t)), longint'(FixedInf()));
    checkOutput("reset bHit", longint'(out_hit.bHit), 0);
    checkOutput("reset ray_id", longint'(out_ray_id), 0);
    checkStats("reset", 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      applyStimulus(v.valid, v.first, v.last, v.bHit, v.t, v.pi, v.id, v.outReady);
      tick();
      checkOutput($sformatf("vec%0d out_valid", i), longint'(out_valid), longint'(v.expValid));
      checkOutput($sformatf("vec%0d in_ready", i), longint'(in_ready), longint'(!v.expValid));
      checkOutput($sformatf("vec%0d cur_max_t", i), longint'($signed(cur_max_t)),
                  longint'(fx(v.expCur)));
      if (v.expValid) checkResult($sformatf("vec%0d", i), v.expBHit, v.expT, v.expPi, v.expId);
    end

    // No-hit ray held under back-pressure while a new first beat waits
    applyStimulus(1, 1, 0, 0, 3, 40, 9, 0);
    tick();
    applyStimulus(1, 0, 1, 0, 1, 41, 0, 0);
    tick();
    checkResult("nohit", 0, INF, 0, 9);
    applyStimulus(1, 1, 1, 1, 7, 42, 12, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkResult($sformatf("stall%0d", k), 0, INF, 0, 9);
      checkOutput($sformatf("stall%0d in_ready", k), longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("handshake out_valid", longint'(out_valid), 0);
    checkOutput("handshake in_ready", longint'(in_ready), 1);
    out_ready = 1'b0;
    tick();
    checkResult("waited ray", 1, 7, 42, 12);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();

    // Asynchronous reset between clock edges while accumulating
    applyStimulus(1, 1, 0, 1, 5, 50, 2, 0);
    tick();
    applyStimulus(1, 0, 0, 1, 3, 51, 0, 0);
    tick();
    checkOutput("pre-reset cur_max_t", longint'($signed(cur_max_t)), longint'(fx(3)));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset cur_max_t", longint'($signed(cur_max_t)), longint'(FixedInf()));
    checkOutput("async reset out_valid", longint'(out_valid), 0);
    checkOutput("async reset ray_id", longint'(out_ray_id), 0);
    #1 reset = 1'b0;
    tick();
    applyStimulus(1, 1, 1, 1, 4, 52, 1, 1);
    tick();
    checkResult("post-reset ray", 1, 4, 52, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("post-reset idle", longint'(out_valid), 0);

    // Protocol errors: restart while accumulating, then a stray beat in IDLE
    applyStimulus(1, 1, 0, 1, 5, 60, 4, 0);
    tick();
    applyStimulus(1, 1, 0, 1, 6, 61, 8, 0);
    tick();
    checkOutput("restart cur_max_t", longint'($signed(cur_max_t)), longint'(fx(6)));
    applyStimulus(1, 0, 1, 1, 2, 62, 0, 0);
    tick();
    checkResult("restart ray", 1, 2, 62, 8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(1, 0, 0, 1, 1, 63, 0, 0);
    tick();
    checkOutput("stray out_valid", longint'(out_valid), 0);
    checkOutput("stray cur_max_t", longint'($signed(cur_max_t)), longint'(FixedInf()));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkStats("proto", 5, 2, 2);

    // Push counters past 2^STAT_W-1 to show saturation
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1, 1, 1, 1, 1, 70 + k, k, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    checkStats("saturate", 15, 15, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
